regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_sb.sv | 70 +++++++
 tb/tb_regfile_sb.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and index type for the scoreboarded register file.
package regfile_pkg;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int ZERO_REG       = 0;
    localparam int A0_REG         = 10;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback bit per register plus a running count of set bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_valid_i,
    input  logic [ADDR_WIDTH-1:0]      set_idx_i,
    input  logic                       clr_valid_i,
    input  logic [ADDR_WIDTH-1:0]      clr_idx_i,
    output logic [2**ADDR_WIDTH-1:0]   pending_o,
    output logic [ADDR_WIDTH:0]        count_o
);
    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0]     pend_q, pend_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                set_eff, clr_eff, inc, dec;

    assign set_eff = set_valid_i && (set_idx_i != ADDR_WIDTH'(ZERO_REG));
    assign clr_eff = clr_valid_i;

    // Set is applied after clear so a same-index issue/writeback stays pending.
    always_comb begin
        pend_d = pend_q;
        if (clr_eff) pend_d[clr_idx_i] = 1'b0;
        if (set_eff) pend_d[set_idx_i] = 1'b1;
        inc   = set_eff && !pend_q[set_idx_i];
        dec   = clr_eff && pend_q[clr_idx_i] && !(set_eff && set_idx_i == clr_idx_i);
        cnt_d = cnt_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_o = pend_q;
    assign count_o   = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with issue/writeback scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_pending,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    output logic [ADDR_WIDTH:0]          pending_cnt,
    output logic [DATA_WIDTH-1:0]        a0
);
    localparam int NREG = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]       pending;
    logic                  wr_eff;

    assign wr_eff = we && (wr_addr != ADDR_WIDTH'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else if (wr_eff) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (iss_valid),
        .set_idx_i   (iss_addr),
        .clr_valid_i (we),
        .clr_idx_i   (wr_addr),
        .pending_o   (pending),
        .count_o     (pending_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  is_zero;
        assign ra      = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = (ra == ADDR_WIDTH'(ZERO_REG));
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by rst_n so reads stay zero while reset is held.
        logic hit;
        assign hit = rst_n && wr_eff && (wr_addr == ra);
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
            is_zero ? '0 : (hit ? wr_data : regs_q[ra]);
        assign rd_pending[i] =
            hit ? (iss_valid && iss_addr == ra) : pending[ra];
`else
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0 : regs_q[ra];
        assign rd_pending[i] = pending[ra];
`endif
    end

    assign a0 = regs_q[A0_REG];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb (2 read ports, 32x32).
module tb_regfile_sb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_pending;
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic [AW:0]      pending_cnt;
    logic [DW-1:0]    a0;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .pending_cnt(pending_cnt), .a0(a0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  p;
        logic [5:0]  cnt;
        logic [31:0] a0;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 0; wr_addr = 0; wr_data = 0; iss_valid = 0; iss_addr = 0;
    endtask

    task automatic step();
        @(posedge clk); @(negedge clk);
    endtask

    vec_t tbl [13];

    initial begin
        // Expected outputs are sampled before the vector's own clock edge.
        //            we wa  wd            iss ia  ra0 ra1 d0            d1            p      cnt a0
        tbl[0]  = '{0, 0,  32'h0,        1,  5,  5,  0,  32'h0,        32'h0,        2'b00, 0, 32'h0};
        tbl[1]  = '{0, 0,  32'h0,        0,  0,  5,  5,  32'h0,        32'h0,        2'b11, 1, 32'h0};
        tbl[2]  = '{1, 5,  32'hDEADBEEF, 0,  0,  6,  1,  32'h0,        32'h0,        2'b00, 1, 32'h0};
        tbl[3]  = '{0, 0,  32'h0,        0,  0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 32'h0};
        tbl[4]  = '{1, 3,  32'h55,       1,  3,  0,  1,  32'h0,        32'h0,        2'b00, 0, 32'h0};
        tbl[5]  = '{0, 0,  32'h0,        0,  0,  3,  5,  32'h55,       32'hDEADBEEF, 2'b01, 1, 32'h0};
        tbl[6]  = '{1, 3,  32'h66,       1,  4,  5,  4,  32'hDEADBEEF, 32'h0,        2'b00, 1, 32'h0};
        tbl[7]  = '{0, 0,  32'h0,        0,  0,  3,  4,  32'h66,       32'h0,        2'b10, 1, 32'h0};
        tbl[8]  = '{1, 0,  32'hFFFFFFFF, 1,  0,  3,  4,  32'h66,       32'h0,        2'b10, 1, 32'h0};
        tbl[9]  = '{1, 10, 32'hA5,       0,  0,  0,  0,  32'h0,        32'h0,        2'b00, 1, 32'h0};
        tbl[10] = '{0, 0,  32'h0,        1,  4,  10, 0,  32'hA5,       32'h0,        2'b00, 1, 32'hA5};
        tbl[11] = '{1, 6,  32'h77,       0,  0,  4,  10, 32'h0,        32'hA5,       2'b01, 1, 32'hA5};
        tbl[12] = '{0, 0,  32'h0,        0,  0,  6,  4,  32'h77,       32'h0,        2'b10, 1, 32'hA5};

        rst_n = 0; rd_addr = '0; idle();
        #1 chk("rst_async_cnt", 64'(pending_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        step();

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            chk($sformatf("reset_rd_x%0d", a), 64'(rd_data), 64'd0);
            chk($sformatf("reset_pend_x%0d", a), 64'(rd_pending), 64'd0);
        end
        chk("reset_cnt", 64'(pending_cnt), 64'd0);
        @(negedge clk);

        for (int k = 0; k < 13; k++) begin
            we = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
            iss_valid = tbl[k].iss; iss_addr = tbl[k].ia;
            rd_addr = {tbl[k].ra1, tbl[k].ra0};
            #1;
            chk($sformatf("v%0d_d0", k), 64'(rd_data[31:0]), 64'(tbl[k].d0));
            chk($sformatf("v%0d_d1", k), 64'(rd_data[63:32]), 64'(tbl[k].d1));
            chk($sformatf("v%0d_pend", k), 64'(rd_pending), 64'(tbl[k].p));
            chk($sformatf("v%0d_cnt", k), 64'(pending_cnt), 64'(tbl[k].cnt));
            chk($sformatf("v%0d_a0", k), 64'(a0), 64'(tbl[k].a0));
            step();
        end
        idle();

        // Same-cycle write and read of x7.
        we = 1; wr_addr = 7; wr_data = 32'h1234; rd_addr = {5'd7, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x7_same_cycle", 64'(rd_data[31:0]), 64'h1234);
        chk("x7_same_cycle_p1", 64'(rd_data[63:32]), 64'h1234);
`else
        chk("x7_same_cycle", 64'(rd_data[31:0]), 64'h0);
        chk("x7_same_cycle_p1", 64'(rd_data[63:32]), 64'h0);
`endif
        step(); idle();
        #1 chk("x7_next_cycle", 64'(rd_data[31:0]), 64'h1234);
        @(negedge clk);

        // Issue x1..x20, then reset mid-cycle while a write is in flight.
        for (int a = 1; a <= 20; a++) begin
            iss_valid = 1; iss_addr = 5'(a);
            step();
        end
        // x4 was already pending, so 19 new entries join it.
        chk("cnt_before_rst", 64'(pending_cnt), 64'd20);
        iss_valid = 1; iss_addr = 21;
        we = 1; wr_addr = 5; wr_data = 32'hCAFE; rd_addr = {5'd10, 5'd5};
        #2 rst_n = 0;
        #1;
        chk("rst_mid_cnt", 64'(pending_cnt), 64'd0);
        chk("rst_mid_data", 64'(rd_data), 64'd0);
        chk("rst_mid_pend", 64'(rd_pending), 64'd0);
        chk("rst_mid_a0", 64'(a0), 64'd0);
        @(posedge clk); #1;
        chk("rst_held_cnt", 64'(pending_cnt), 64'd0);
        chk("rst_held_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        idle();
        rst_n = 1;
        #1 chk("post_rst_data", 64'(rd_data), 64'd0);
        step();
        chk("post_rst_cnt", 64'(pending_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
